// File: rtl/med_job_scheduler_if.sv
// ---------------------------------------------------------------------------
// med_job_scheduler_if
//   Avalon-MM bus between the processor (master) and the job scheduler
//   register file (slave). Word addressed, 64-bit data, zero wait states.
//
//   avm_main_address    6   word address
//   avm_main_read       1   read strobe
//   avm_main_write      1   write strobe
//   avm_main_writedata  64  write data
//   avm_main_byteenable 8   byte enables (the scheduler treats all writes as full words)
//   avm_main_readdata   64  read data, combinational from address
// ---------------------------------------------------------------------------
interface med_job_scheduler_if;
    logic [5:0]  avm_main_address;
    logic        avm_main_read;
    logic        avm_main_write;
    logic [63:0] avm_main_writedata;
    logic [7:0]  avm_main_byteenable;
    logic [63:0] avm_main_readdata;

    modport master (
        output avm_main_address,
        output avm_main_read,
        output avm_main_write,
        output avm_main_writedata,
        output avm_main_byteenable,
        input  avm_main_readdata
    );

    modport slave (
        input  avm_main_address,
        input  avm_main_read,
        input  avm_main_write,
        input  avm_main_writedata,
        input  avm_main_byteenable,
        output avm_main_readdata
    );
endinterface

// File: rtl/med_job_scheduler.sv
// ---------------------------------------------------------------------------
// med_job_scheduler
//   Sequences one med_solver run at a time for the processor: holds the
//   sequence lengths and 2-bit-per-base sequences in a register file, pulses
//   the solver reset, waits for solver_finished, latches the alignment result
//   into stable readback registers and raises a level interrupt.
//
//   Optional feature: define MED_SCHED_WATCHDOG_EN to end a run in DONE with
//   the timeout flag once the RUN cycle counter reaches TIMEOUT_CYCLES.
//   Without it a run waits for solver_finished indefinitely.
//
//   Ports
//     clk              system clock
//     rst              asynchronous active-low reset
//     avm              Avalon-MM slave (med_job_scheduler_if.slave)
//     irq              level interrupt: done and irq_en
//     solver_rst       active-high solver reset, low only in RUN
//     solver_len1/2    registered sequence lengths
//     solver_seq1/2    packed bases, base i at [2i+:2]
//     solver_finished  solver completion
//     solver_aligned   packed direction trace
//     solver_max_row/col  best-score cell
//
//   Address map (64-bit words): 0 CTRL(w)/STATUS(r), 1 LEN, 2-3 seq1,
//   4-5 seq2, 8-10 result trace, 11 max_row/max_col. Others read 0.
// ---------------------------------------------------------------------------
module med_job_scheduler #(
    parameter int MAX_LEN1       = 46,
    parameter int MAX_LEN2       = 46,
    parameter int RST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                             clk,
    input  logic                             rst,
    med_job_scheduler_if.slave               avm,
    output logic                             irq,
    output logic                             solver_rst,
    output logic [7:0]                       solver_len1,
    output logic [7:0]                       solver_len2,
    output logic [2*MAX_LEN1-1:0]            solver_seq1,
    output logic [2*MAX_LEN2-1:0]            solver_seq2,
    input  logic                             solver_finished,
    input  logic [2*(MAX_LEN1+MAX_LEN2)-1:0] solver_aligned,
    input  logic [7:0]                       solver_max_row,
    input  logic [7:0]                       solver_max_col
);
    localparam int          TRACE_W     = 2 * (MAX_LEN1 + MAX_LEN2);
    localparam int          TRACE_WORDS = 3;
    localparam logic [7:0]  LEN1_MAX    = 8'(MAX_LEN1);
    localparam logic [7:0]  LEN2_MAX    = 8'(MAX_LEN2);
    localparam logic [15:0] RST_LOAD    = 16'(RST_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, PRERST, RUN, DONE} state_t;

    state_t             state_reg;
    logic               solver_rst_reg;
    logic               irq_en_reg;
    logic               done_reg;
    logic               timeout_reg;
    logic               len_err_reg;
    logic [15:0]        rst_cnt_reg;
    logic [15:0]        cycle_cnt_reg;
    logic [7:0]         job_cnt_reg;
    logic [7:0]         len1_reg;
    logic [7:0]         len2_reg;
    logic [127:0]       seq1_reg;
    logic [127:0]       seq2_reg;
    logic [TRACE_W-1:0] res_trace_reg;
    logic [7:0]         res_row_reg;
    logic [7:0]         res_col_reg;

    logic [5:0]  addr;
    logic [63:0] wdata;
    logic        ctrl_wr;
    logic        start_cmd;
    logic        abort_cmd;
    logic        ack_cmd;
    logic        cfg_wr;
    logic        busy;
    logic        len_ok;
    logic        wd_enabled;
    logic        wd_hit;
    logic [15:0] cycle_cnt_inc;
    logic        unused_bus;

    assign addr  = avm.avm_main_address;
    assign wdata = avm.avm_main_writedata;
    // Reads have no side effects and every write is a full word.
    assign unused_bus = ^{avm.avm_main_read, avm.avm_main_byteenable};

    assign busy      = (state_reg == PRERST) || (state_reg == RUN);
    assign ctrl_wr   = avm.avm_main_write && (addr == 6'd0);
    // Abort wins over a start in the same write.
    assign start_cmd = ctrl_wr && wdata[0] && !wdata[1];
    assign abort_cmd = ctrl_wr && wdata[1];
    assign ack_cmd   = ctrl_wr && wdata[2];
    // Job configuration is frozen while the solver is being driven.
    assign cfg_wr    = avm.avm_main_write && !busy;
    assign len_ok    = (len1_reg != 8'd0) && (len1_reg <= LEN1_MAX) &&
                       (len2_reg != 8'd0) && (len2_reg <= LEN2_MAX);

    assign cycle_cnt_inc = (cycle_cnt_reg == 16'hFFFF) ? cycle_cnt_reg : cycle_cnt_reg + 16'd1;

`ifdef MED_SCHED_WATCHDOG_EN
    assign wd_enabled = 1'b1;
`else
    assign wd_enabled = 1'b0;
`endif
    // Fires on the RUN edge where the counter would reach the limit.
    assign wd_hit = wd_enabled && (cycle_cnt_inc == TIMEOUT_VAL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            solver_rst_reg <= 1'b1;
            irq_en_reg     <= 1'b0;
            done_reg       <= 1'b0;
            timeout_reg    <= 1'b0;
            len_err_reg    <= 1'b0;
            rst_cnt_reg    <= '0;
            cycle_cnt_reg  <= '0;
            job_cnt_reg    <= '0;
            len1_reg       <= '0;
            len2_reg       <= '0;
            seq1_reg       <= '0;
            seq2_reg       <= '0;
            res_trace_reg  <= '0;
            res_row_reg    <= '0;
            res_col_reg    <= '0;
        end else begin
            if (ctrl_wr) begin
                irq_en_reg <= wdata[3];
            end
            if (cfg_wr) begin
                case (addr)
                    6'd1: begin
                        len1_reg <= wdata[7:0];
                        len2_reg <= wdata[15:8];
                    end
                    6'd2:    seq1_reg[63:0]   <= wdata;
                    6'd3:    seq1_reg[127:64] <= wdata;
                    6'd4:    seq2_reg[63:0]   <= wdata;
                    6'd5:    seq2_reg[127:64] <= wdata;
                    default: ;
                endcase
            end

            case (state_reg)
                // A start in DONE acts as an ack followed by the start.
                IDLE, DONE: begin
                    if (start_cmd) begin
                        done_reg <= 1'b0;
                        if (len_ok) begin
                            state_reg     <= PRERST;
                            rst_cnt_reg   <= RST_LOAD;
                            cycle_cnt_reg <= '0;
                            timeout_reg   <= 1'b0;
                            len_err_reg   <= 1'b0;
                        end else begin
                            len_err_reg <= 1'b1;
                            state_reg   <= IDLE;
                        end
                    end else if (ack_cmd) begin
                        done_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                PRERST: begin
                    if (abort_cmd) begin
                        state_reg <= IDLE;
                    end else if (rst_cnt_reg == '0) begin
                        state_reg      <= RUN;
                        solver_rst_reg <= 1'b0;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg - 16'd1;
                    end
                end
                RUN: begin
                    if (abort_cmd) begin
                        state_reg      <= IDLE;
                        solver_rst_reg <= 1'b1;
                    end else begin
                        cycle_cnt_reg <= cycle_cnt_inc;
                        // A finish on the watchdog edge still counts as success.
                        if (solver_finished) begin
                            res_trace_reg  <= solver_aligned;
                            res_row_reg    <= solver_max_row;
                            res_col_reg    <= solver_max_col;
                            job_cnt_reg    <= job_cnt_reg + 8'd1;
                            done_reg       <= 1'b1;
                            state_reg      <= DONE;
                            solver_rst_reg <= 1'b1;
                        end else if (wd_hit) begin
                            timeout_reg    <= 1'b1;
                            done_reg       <= 1'b1;
                            state_reg      <= DONE;
                            solver_rst_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign irq         = done_reg & irq_en_reg;
    assign solver_rst  = solver_rst_reg;
    assign solver_len1 = len1_reg;
    assign solver_len2 = len2_reg;
    assign solver_seq1 = seq1_reg[2*MAX_LEN1-1:0];
    assign solver_seq2 = seq2_reg[2*MAX_LEN2-1:0];

    // The trace is zero-extended to a whole number of 64-bit words.
    logic [64*TRACE_WORDS-1:0] trace_pad;
    logic [63:0]               trace_word [TRACE_WORDS];

    always_comb begin
        trace_pad                = '0;
        trace_pad[TRACE_W-1:0]   = res_trace_reg;
    end

    generate
        for (genvar gi = 0; gi < TRACE_WORDS; gi++) begin : g_trace_word
            assign trace_word[gi] = trace_pad[64*gi +: 64];
        end
    endgenerate

    always_comb begin
        avm.avm_main_readdata = '0;
        case (addr)
            6'd0:  avm.avm_main_readdata = {32'd0, job_cnt_reg, cycle_cnt_reg, 3'd0, irq_en_reg,
                                            len_err_reg, timeout_reg, done_reg, busy};
            6'd1:  avm.avm_main_readdata = {48'd0, len2_reg, len1_reg};
            6'd2:  avm.avm_main_readdata = seq1_reg[63:0];
            6'd3:  avm.avm_main_readdata = seq1_reg[127:64];
            6'd4:  avm.avm_main_readdata = seq2_reg[63:0];
            6'd5:  avm.avm_main_readdata = seq2_reg[127:64];
            6'd8:  avm.avm_main_readdata = trace_word[0];
            6'd9:  avm.avm_main_readdata = trace_word[1];
            6'd10: avm.avm_main_readdata = trace_word[2];
            6'd11: avm.avm_main_readdata = {48'd0, res_col_reg, res_row_reg};
            default: ;
        endcase
    end
endmodule
